// File: rtl/decode_bus_arbiter_pkg.sv
// Shared definitions for the decode bus arbiter: bus widths, FSM state
// encoding and the addresses the decode register block treats specially.
package bus_pkg;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 8;

    // Addresses with dedicated behaviour inside the decode block
    localparam logic [ADDR_W-1:0] DEC_MAP_HI  = 8'hF0;
    localparam logic [ADDR_W-1:0] DEC_MAP_LO  = 8'h0F;
    localparam logic [ADDR_W-1:0] DEC_MAP_ALL = 8'hA0;

    // Arbiter FSM: grant in IDLE, drive decode in ISSUE, collect result in CAPTURE
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2
    } state_t;

endpackage

// File: rtl/decode_bus_arbiter_rr_pick.sv
// Combinational round-robin selector: the winner is the first asserted
// request found scanning upward from rr_ptr+1, wrapping modulo NUM_REQ.
module rr_pick #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] rr_ptr,
    output logic [$clog2(NUM_REQ)-1:0] winner,
    output logic                       any_valid
);

    localparam int IDX_W = $clog2(NUM_REQ);

    // cand_idx[k] is the requester that holds priority rank k this cycle
    logic [IDX_W-1:0] cand_idx [NUM_REQ];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_cand
            assign cand_idx[gi] = IDX_W'((int'(rr_ptr) + 1 + gi) % NUM_REQ);
        end
    endgenerate

    // Scan from lowest to highest priority so the highest-ranked hit wins
    always_comb begin
        winner    = '0;
        any_valid = 1'b0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[cand_idx[i]]) begin
                winner    = cand_idx[i];
                any_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/decode_bus_arbiter.sv
// Round-robin arbiter sharing the single address/data port of the decode
// register block between NUM_REQ requesters, with bounded burst locking.
// Every output comes straight from a register.
module decode_bus_arbiter
    import bus_pkg::*;
#(
    parameter int                NUM_REQ   = 4,
    parameter int                MAX_BURST = 4,
    parameter logic [ADDR_W-1:0] IDLE_ADDR = 8'h00
) (
    input  logic                        clock,
    input  logic                        reset_n,
    input  logic [NUM_REQ-1:0]          req,
    input  logic [NUM_REQ-1:0]          lock,
    input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    output logic [NUM_REQ-1:0]          gnt,
    output logic [NUM_REQ-1:0]          rsp_valid,
    output logic [DATA_W-1:0]           rsp_data,
    output logic                        busy,
    output logic [$clog2(NUM_REQ)-1:0]  owner,
    output logic [ADDR_W-1:0]           dec_addr,
    output logic [DATA_W-1:0]           dec_data,
    input  logic [DATA_W-1:0]           dec_rdata
);

    localparam int IDX_W = $clog2(NUM_REQ);

    state_t              state_reg;
    logic [NUM_REQ-1:0]  gnt_reg;
    logic [NUM_REQ-1:0]  rsp_valid_reg;
    logic [DATA_W-1:0]   rsp_data_reg;
    logic                busy_reg;
    logic [IDX_W-1:0]    owner_reg;
    logic [ADDR_W-1:0]   dec_addr_reg;
    logic [DATA_W-1:0]   dec_data_reg;
    logic [IDX_W-1:0]    rr_ptr_reg;
    logic [3:0]          burst_cnt_reg;

    logic [IDX_W-1:0]    pick_winner;
    logic                pick_any;
    logic                burst_go;

    // Per-requester operand views of the packed input buses
    logic [ADDR_W-1:0]   addr_arr [NUM_REQ];
    logic [DATA_W-1:0]   data_arr [NUM_REQ];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_operands
            assign addr_arr[gi] = req_addr[gi*ADDR_W +: ADDR_W];
            assign data_arr[gi] = req_data[gi*DATA_W +: DATA_W];
        end
    endgenerate

    rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_pick (
        .req       (req),
        .rr_ptr    (rr_ptr_reg),
        .winner    (pick_winner),
        .any_valid (pick_any)
    );

    // The owner may chain another beat only while it still asks, still locks
    // and has not used up its tenure; otherwise the bus is released.
    assign burst_go = req[owner_reg] && lock[owner_reg] &&
                      (burst_cnt_reg < 4'(MAX_BURST));

    // Arbitration FSM with registered grant, bus drive and response outputs
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg     <= IDLE;
            gnt_reg       <= '0;
            rsp_valid_reg <= '0;
            rsp_data_reg  <= '0;
            busy_reg      <= 1'b0;
            owner_reg     <= '0;
            dec_addr_reg  <= IDLE_ADDR;
            dec_data_reg  <= '0;
            rr_ptr_reg    <= IDX_W'(NUM_REQ - 1);
            burst_cnt_reg <= '0;
        end else begin
            // Grant and response are single-cycle pulses
            gnt_reg       <= '0;
            rsp_valid_reg <= '0;
            case (state_reg)
                IDLE: begin
                    if (pick_any) begin
                        owner_reg     <= pick_winner;
                        dec_addr_reg  <= addr_arr[pick_winner];
                        dec_data_reg  <= data_arr[pick_winner];
                        gnt_reg       <= NUM_REQ'(1) << pick_winner;
                        rr_ptr_reg    <= pick_winner;
                        burst_cnt_reg <= 4'd1;
                        busy_reg      <= 1'b1;
                        state_reg     <= ISSUE;
                    end else begin
                        dec_addr_reg  <= IDLE_ADDR;
                        dec_data_reg  <= '0;
                        busy_reg      <= 1'b0;
                    end
                end
                ISSUE: begin
                    // decode samples the bus at the end of this cycle
                    state_reg <= CAPTURE;
                end
                CAPTURE: begin
                    rsp_data_reg  <= dec_rdata;
                    rsp_valid_reg <= NUM_REQ'(1) << owner_reg;
                    if (burst_go) begin
                        dec_addr_reg  <= addr_arr[owner_reg];
                        dec_data_reg  <= data_arr[owner_reg];
                        gnt_reg       <= NUM_REQ'(1) << owner_reg;
                        burst_cnt_reg <= burst_cnt_reg + 4'd1;
                        state_reg     <= ISSUE;
                    end else begin
                        dec_addr_reg  <= IDLE_ADDR;
                        dec_data_reg  <= '0;
                        busy_reg      <= 1'b0;
                        state_reg     <= IDLE;
                    end
                end
                default: begin
                    dec_addr_reg <= IDLE_ADDR;
                    dec_data_reg <= '0;
                    busy_reg     <= 1'b0;
                    state_reg    <= IDLE;
                end
            endcase
        end
    end

    assign gnt       = gnt_reg;
    assign rsp_valid = rsp_valid_reg;
    assign rsp_data  = rsp_data_reg;
    assign busy      = busy_reg;
    assign owner     = owner_reg;
    assign dec_addr  = dec_addr_reg;
    assign dec_data  = dec_data_reg;

endmodule
